// File: rtl/multi_wait_timer_if.sv
// Control, limit-programming and status bundle for multi_wait_timer.
interface multi_wait_timer_if #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]           start;
    logic [NUM_CH-1:0]           stop;
    logic [NUM_CH-1:0]           clear;
    logic [NUM_CH-1:0]           mode;
    logic                        limit_wr;
    logic [CH_W-1:0]             limit_ch;
    logic [CNT_WIDTH-1:0]        limit_data;
    logic [NUM_CH-1:0]           reach_limit;
    logic [NUM_CH-1:0]           busy;
    logic [NUM_CH*CNT_WIDTH-1:0] count_flat;

    modport master (
        output start, stop, clear, mode, limit_wr, limit_ch, limit_data,
        input  reach_limit, busy, count_flat
    );

    modport slave (
        input  start, stop, clear, mode, limit_wr, limit_ch, limit_data,
        output reach_limit, busy, count_flat
    );
endinterface

// File: rtl/multi_wait_timer.sv
// Multi-channel programmable wait/timeout counter with per-channel
// level-pulse or start/stop modes and synchronised control inputs.
//
// state | meaning
// IDLE  | counter parked at 0, waiting for start (also used by mode 0)
// RUN   | counting up, busy high
// HOLD  | paused by stop, counter frozen
module multi_wait_timer #(
    parameter int NUM_CH        = 4,
    parameter int CNT_WIDTH     = 16,
    parameter int DEFAULT_LIMIT = 100,
    parameter int SYNC_STAGES   = 2,
    parameter int LEVEL_POL     = 1
) (
    input logic               clk,
    input logic               rst,
    multi_wait_timer_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

    localparam logic [CNT_WIDTH-1:0] LIMIT_RST  = CNT_WIDTH'(DEFAULT_LIMIT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic                 ACTIVE_LVL = (LEVEL_POL != 0);

    logic [NUM_CH-1:0]    start_sync [SYNC_STAGES];
    logic [NUM_CH-1:0]    stop_sync  [SYNC_STAGES];
    logic [NUM_CH-1:0]    clear_sync [SYNC_STAGES];
    logic [NUM_CH-1:0]    start_s;
    logic [NUM_CH-1:0]    stop_s;
    logic [NUM_CH-1:0]    clear_s;

    logic [CNT_WIDTH-1:0] limit_q [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_q   [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_d   [NUM_CH];
    state_t               state_q [NUM_CH];
    state_t               state_d [NUM_CH];

    logic [NUM_CH-1:0]    mode_q;
    logic [NUM_CH-1:0]    mode_chg;
    logic [NUM_CH-1:0]    level_on;
    logic [NUM_CH-1:0]    term;
    logic [NUM_CH-1:0]    reach_q;
    logic [NUM_CH-1:0]    reach_d;
    logic [NUM_CH-1:0]    busy_q;
    logic [NUM_CH-1:0]    busy_d;

    // Synchroniser chains for the asynchronous start/stop/clear pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                start_sync[i] <= '0;
                stop_sync[i]  <= '0;
                clear_sync[i] <= '0;
            end
        end else begin
            start_sync[0] <= bus.start;
            stop_sync[0]  <= bus.stop;
            clear_sync[0] <= bus.clear;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                start_sync[i] <= start_sync[i-1];
                stop_sync[i]  <= stop_sync[i-1];
                clear_sync[i] <= clear_sync[i-1];
            end
        end
    end

    assign start_s = start_sync[SYNC_STAGES-1];
    assign stop_s  = stop_sync[SYNC_STAGES-1];
    assign clear_s = clear_sync[SYNC_STAGES-1];

    // Limit register bank; writes to a non-existent channel are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                limit_q[i] <= LIMIT_RST;
            end
        end else if (bus.limit_wr && (int'(bus.limit_ch) < NUM_CH)) begin
            limit_q[bus.limit_ch] <= bus.limit_data;
        end
    end

    // >= rather than == so a limit lowered below the count still terminates.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            term[i] = (cnt_q[i] >= limit_q[i]);
        end
    end

    assign mode_chg = bus.mode ^ mode_q;
    assign level_on = ~clear_s & ~(start_s ^ {NUM_CH{ACTIVE_LVL}});

    // Per-channel next state, counter, pulse and busy.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            reach_d[i] = 1'b0;
            busy_d[i]  = 1'b0;
            if (mode_chg[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else if (!bus.mode[i]) begin
                state_d[i] = IDLE;
                if (!level_on[i]) begin
                    cnt_d[i] = '0;
                end else begin
                    busy_d[i] = 1'b1;
                    if (term[i]) begin
                        cnt_d[i]   = '0;
                        reach_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (!clear_s[i] && start_s[i]) begin
                            state_d[i] = RUN;
                            cnt_d[i]   = CNT_ONE;
                            busy_d[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = '0;
                        end
                    end
                    RUN: begin
                        if (clear_s[i]) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end else if (term[i]) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                            reach_d[i] = 1'b1;
                        end else if (stop_s[i]) begin
                            state_d[i] = HOLD;
                        end else begin
                            cnt_d[i]  = cnt_q[i] + CNT_ONE;
                            busy_d[i] = 1'b1;
                        end
                    end
                    HOLD: begin
                        if (clear_s[i]) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end else if (start_s[i]) begin
                            state_d[i] = RUN;
                            cnt_d[i]   = cnt_q[i] + CNT_ONE;
                            busy_d[i]  = 1'b1;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            mode_q  <= '0;
            reach_q <= '0;
            busy_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            mode_q  <= bus.mode;
            reach_q <= reach_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.reach_limit = reach_q;
    assign bus.busy        = busy_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_count
        assign bus.count_flat[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
    end
endmodule

// File: tb/tb_multi_wait_timer.sv
// Bench for multi_wait_timer: directed scenarios plus random traffic,
// checked against a behavioural per-channel model.
module tb_multi_wait_timer;
    localparam int NUM_CH        = 4;
    localparam int CNT_WIDTH     = 16;
    localparam int DEFAULT_LIMIT = 100;
    localparam int SYNC_STAGES   = 2;
    localparam int LEVEL_POL     = 1;
    localparam int CH_W          = 2;
    localparam int CW            = NUM_CH * CNT_WIDTH;
    localparam bit LVL           = (LEVEL_POL != 0);

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    multi_wait_timer_if #(.NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    multi_wait_timer #(
        .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .DEFAULT_LIMIT(DEFAULT_LIMIT),
        .SYNC_STAGES(SYNC_STAGES), .LEVEL_POL(LEVEL_POL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Behavioural model: per channel a count, a running/paused pair, and the
    // input history seen through the synchroniser delay.
    int m_cnt     [NUM_CH];
    int m_lim     [NUM_CH];
    bit m_reach   [NUM_CH];
    bit m_busy    [NUM_CH];
    bit m_running [NUM_CH];
    bit m_paused  [NUM_CH];
    bit m_prev_mode [NUM_CH];
    bit q_start [NUM_CH][$];
    bit q_stop  [NUM_CH][$];
    bit q_clear [NUM_CH][$];

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = 0; m_lim[c] = DEFAULT_LIMIT; m_reach[c] = 0; m_busy[c] = 0;
            m_running[c] = 0; m_paused[c] = 0; m_prev_mode[c] = 0;
            q_start[c].delete(); q_stop[c].delete(); q_clear[c].delete();
            repeat (SYNC_STAGES) begin
                q_start[c].push_back(1'b0); q_stop[c].push_back(1'b0); q_clear[c].push_back(1'b0);
            end
        end
    endtask

    // Predicts the effect of the next rising edge from the currently driven inputs.
    task automatic model_edge();
        bit s_st, s_sp, s_cl;
        for (int c = 0; c < NUM_CH; c++) begin
            s_st = q_start[c][0];
            s_sp = q_stop[c][0];
            s_cl = q_clear[c][0];
            m_reach[c] = 0;
            if (bus.mode[c] != m_prev_mode[c]) begin
                m_running[c] = 0; m_paused[c] = 0; m_cnt[c] = 0; m_busy[c] = 0;
            end else if (bus.mode[c] == 1'b0) begin
                m_running[c] = 0; m_paused[c] = 0;
                m_busy[c] = !s_cl && (s_st == LVL);
                if (!m_busy[c]) m_cnt[c] = 0;
                else if (m_cnt[c] >= m_lim[c]) begin m_cnt[c] = 0; m_reach[c] = 1; end
                else m_cnt[c] = m_cnt[c] + 1;
            end else begin
                if (s_cl) begin
                    m_running[c] = 0; m_paused[c] = 0; m_cnt[c] = 0;
                end else if (m_running[c]) begin
                    if (m_cnt[c] >= m_lim[c]) begin m_running[c] = 0; m_cnt[c] = 0; m_reach[c] = 1; end
                    else if (s_sp) begin m_running[c] = 0; m_paused[c] = 1; end
                    else m_cnt[c] = m_cnt[c] + 1;
                end else if (s_st) begin
                    m_cnt[c] = m_paused[c] ? m_cnt[c] + 1 : 1;
                    m_running[c] = 1; m_paused[c] = 0;
                end else if (!m_paused[c]) begin
                    m_cnt[c] = 0;
                end
                m_busy[c] = m_running[c];
            end
            m_prev_mode[c] = bus.mode[c];
            void'(q_start[c].pop_front()); q_start[c].push_back(bus.start[c]);
            void'(q_stop[c].pop_front());  q_stop[c].push_back(bus.stop[c]);
            void'(q_clear[c].pop_front()); q_clear[c].push_back(bus.clear[c]);
        end
        if (bus.limit_wr && int'(bus.limit_ch) < NUM_CH) m_lim[bus.limit_ch] = int'(bus.limit_data);
    endtask

    function automatic logic [CW-1:0] exp_count();
        logic [CW-1:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++) v[c*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(m_cnt[c]);
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_reach();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_reach[c];
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_busy();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_busy[c];
        return v;
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_limit(input int ch, input int val);
        bus.limit_wr = 1'b1; bus.limit_ch = CH_W'(ch); bus.limit_data = CNT_WIDTH'(val);
        tick();
        bus.limit_wr = 1'b0;
    endtask

    task automatic test_reset();
        int run_at, reach_at;
        rst = 1'b1;
        bus.start = '0; bus.stop = '0; bus.clear = '0; bus.mode = '0;
        bus.limit_wr = 1'b0; bus.limit_ch = '0; bus.limit_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks += 3;
        if (bus.count_flat !== '0) begin errors++; $display("FAIL reset_count: got %h expected 0", bus.count_flat); end
        if (bus.reach_limit !== '0) begin errors++; $display("FAIL reset_reach: got %b expected 0", bus.reach_limit); end
        if (bus.busy !== '0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        rst = 1'b0;
        bus.mode[0] = 1'b1; tick();
        bus.start[0] = 1'b1; tick(); bus.start[0] = 1'b0;
        repeat (20) tick();
        checks += 2;
        if (bus.busy[0] !== 1'b1) begin errors++; $display("FAIL reset_precount_busy: got %b expected 1", bus.busy[0]); end
        if (bus.count_flat !== exp_count()) begin errors++; $display("FAIL reset_precount: got %h expected %h", bus.count_flat, exp_count()); end
        #3 rst = 1'b1;
        #1;
        checks += 3;
        if (bus.count_flat !== '0) begin errors++; $display("FAIL reset_async_count: got %h expected 0", bus.count_flat); end
        if (bus.reach_limit !== '0) begin errors++; $display("FAIL reset_async_reach: got %b expected 0", bus.reach_limit); end
        if (bus.busy !== '0) begin errors++; $display("FAIL reset_async_busy: got %b expected 0", bus.busy); end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        checks++;
        if (bus.count_flat !== '0) begin errors++; $display("FAIL reset_release_count: got %h expected 0", bus.count_flat); end
        bus.start[0] = 1'b1; tick(); bus.start[0] = 1'b0;
        run_at = -1; reach_at = -1;
        for (int t = 1; t <= 150 && reach_at < 0; t++) begin
            tick();
            checks += 2;
            if (bus.count_flat !== exp_count()) begin errors++; $display("FAIL default_trace_count: got %h expected %h", bus.count_flat, exp_count()); end
            if (bus.reach_limit !== exp_reach()) begin errors++; $display("FAIL default_trace_reach: got %b expected %b", bus.reach_limit, exp_reach()); end
            if (bus.busy[0] && run_at < 0) run_at = t;
            if (bus.reach_limit[0]) reach_at = t;
        end
        checks++;
        if (run_at < 0 || reach_at < 0) begin errors++; $display("FAIL default_limit_timeout: run %0d reach %0d expected both seen", run_at, reach_at); end
        else if (reach_at - run_at != 100) begin errors++; $display("FAIL default_limit: got %0d cycles expected 100", reach_at - run_at); end
    endtask

    task automatic test_mode0_periodic();
        int first, last, npulse;
        set_limit(1, 5);
        bus.start[1] = 1'b1;
        first = -1; last = -1; npulse = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            checks += 3;
            if (bus.count_flat !== exp_count()) begin errors++; $display("FAIL mode0_count: got %h expected %h", bus.count_flat, exp_count()); end
            if (bus.reach_limit !== exp_reach()) begin errors++; $display("FAIL mode0_reach: got %b expected %b", bus.reach_limit, exp_reach()); end
            if (bus.busy !== exp_busy()) begin errors++; $display("FAIL mode0_busy: got %b expected %b", bus.busy, exp_busy()); end
            if (bus.reach_limit[1]) begin
                if (first < 0) first = t;
                else begin
                    checks++;
                    if (t - last != 6) begin errors++; $display("FAIL mode0_period: got %0d expected 6", t - last); end
                end
                last = t; npulse++;
            end
        end
        checks += 2;
        if (first != SYNC_STAGES + 6) begin errors++; $display("FAIL mode0_first: got %0d expected %0d", first, SYNC_STAGES + 6); end
        if (npulse != 6) begin errors++; $display("FAIL mode0_npulse: got %0d expected 6", npulse); end
        bus.start[1] = 1'b0;
        repeat (SYNC_STAGES + 1) tick();
        checks += 2;
        if (bus.count_flat[CNT_WIDTH +: CNT_WIDTH] !== '0) begin errors++; $display("FAIL mode0_drop_count: got %0d expected 0", bus.count_flat[CNT_WIDTH +: CNT_WIDTH]); end
        if (bus.busy[1] !== 1'b0) begin errors++; $display("FAIL mode0_drop_busy: got %b expected 0", bus.busy[1]); end
        npulse = 0;
        repeat (20) begin tick(); if (bus.reach_limit[1]) npulse++; end
        checks++;
        if (npulse != 0) begin errors++; $display("FAIL mode0_after_drop: got %0d pulses expected 0", npulse); end
    endtask

    task automatic test_pause_resume();
        bit seen;
        int resume_at, reach_at;
        bus.mode[2] = 1'b1; tick();
        set_limit(2, 10);
        bus.start[2] = 1'b1; tick(); bus.start[2] = 1'b0;
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin tick(); seen = bus.busy[2]; end
        checks++;
        if (!seen) begin errors++; $display("FAIL pause_start_timeout: busy %b expected 1", bus.busy[2]); end
        tick();
        bus.stop[2] = 1'b1;
        repeat (7) begin
            tick();
            checks += 2;
            if (bus.count_flat !== exp_count()) begin errors++; $display("FAIL pause_count: got %h expected %h", bus.count_flat, exp_count()); end
            if (bus.busy !== exp_busy()) begin errors++; $display("FAIL pause_busy_trace: got %b expected %b", bus.busy, exp_busy()); end
        end
        checks += 2;
        if (bus.count_flat[2*CNT_WIDTH +: CNT_WIDTH] !== 16'd4) begin errors++; $display("FAIL pause_frozen: got %0d expected 4", bus.count_flat[2*CNT_WIDTH +: CNT_WIDTH]); end
        if (bus.busy[2] !== 1'b0) begin errors++; $display("FAIL pause_busy: got %b expected 0", bus.busy[2]); end
        bus.stop[2] = 1'b0; bus.start[2] = 1'b1; tick(); bus.start[2] = 1'b0;
        resume_at = -1; reach_at = -1;
        for (int t = 1; t <= 30 && reach_at < 0; t++) begin
            tick();
            checks++;
            if (bus.count_flat !== exp_count()) begin errors++; $display("FAIL resume_count: got %h expected %h", bus.count_flat, exp_count()); end
            if (bus.busy[2] && resume_at < 0) resume_at = t;
            if (bus.reach_limit[2]) reach_at = t;
        end
        checks++;
        if (resume_at < 0 || reach_at < 0) begin errors++; $display("FAIL resume_timeout: resume %0d reach %0d expected both seen", resume_at, reach_at); end
        else if (reach_at - resume_at != 6) begin errors++; $display("FAIL resume_gap: got %0d expected 6", reach_at - resume_at); end
    endtask

    task automatic test_clear_priority();
        bit seen;
        bus.start[2] = 1'b1; tick(); bus.start[2] = 1'b0;
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin tick(); seen = bus.busy[2]; end
        checks++;
        if (!seen) begin errors++; $display("FAIL clear_start_timeout: busy %b expected 1", bus.busy[2]); end
        repeat (6) tick();
        checks++;
        if (bus.count_flat[2*CNT_WIDTH +: CNT_WIDTH] !== 16'd7) begin errors++; $display("FAIL clear_precount: got %0d expected 7", bus.count_flat[2*CNT_WIDTH +: CNT_WIDTH]); end
        bus.clear[2] = 1'b1; bus.stop[2] = 1'b1;
        tick(); tick();
        checks++;
        if (bus.count_flat[2*CNT_WIDTH +: CNT_WIDTH] !== 16'd9) begin errors++; $display("FAIL clear_at_9: got %0d expected 9", bus.count_flat[2*CNT_WIDTH +: CNT_WIDTH]); end
        tick();
        checks += 3;
        if (bus.count_flat[2*CNT_WIDTH +: CNT_WIDTH] !== '0) begin errors++; $display("FAIL clear_count: got %0d expected 0", bus.count_flat[2*CNT_WIDTH +: CNT_WIDTH]); end
        if (bus.busy[2] !== 1'b0) begin errors++; $display("FAIL clear_busy: got %b expected 0", bus.busy[2]); end
        if (bus.reach_limit[2] !== 1'b0) begin errors++; $display("FAIL clear_reach: got %b expected 0", bus.reach_limit[2]); end
        repeat (4) begin
            tick();
            checks += 2;
            if (bus.reach_limit !== exp_reach()) begin errors++; $display("FAIL clear_no_reach: got %b expected %b", bus.reach_limit, exp_reach()); end
            if (bus.count_flat !== exp_count()) begin errors++; $display("FAIL clear_hold_count: got %h expected %h", bus.count_flat, exp_count()); end
        end
        bus.clear[2] = 1'b0; bus.stop[2] = 1'b0;
        repeat (SYNC_STAGES + 1) tick();
    endtask

    task automatic test_limit_lower();
        bit seen;
        bus.mode[3] = 1'b1; tick();
        bus.start[3] = 1'b1; tick(); bus.start[3] = 1'b0;
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin tick(); seen = bus.busy[3]; end
        checks++;
        if (!seen) begin errors++; $display("FAIL lower_start_timeout: busy %b expected 1", bus.busy[3]); end
        repeat (49) tick();
        checks++;
        if (bus.count_flat[3*CNT_WIDTH +: CNT_WIDTH] !== 16'd50) begin errors++; $display("FAIL lower_at_50: got %0d expected 50", bus.count_flat[3*CNT_WIDTH +: CNT_WIDTH]); end
        bus.limit_wr = 1'b1; bus.limit_ch = CH_W'(3); bus.limit_data = 16'd20;
        tick();
        bus.limit_wr = 1'b0;
        checks++;
        if (bus.count_flat[3*CNT_WIDTH +: CNT_WIDTH] !== 16'd51) begin errors++; $display("FAIL lower_write_cycle: got %0d expected 51", bus.count_flat[3*CNT_WIDTH +: CNT_WIDTH]); end
        tick();
        checks += 2;
        if (bus.reach_limit[3] !== 1'b1) begin errors++; $display("FAIL lower_reach: got %b expected 1", bus.reach_limit[3]); end
        if (bus.count_flat[3*CNT_WIDTH +: CNT_WIDTH] !== '0) begin errors++; $display("FAIL lower_count: got %0d expected 0", bus.count_flat[3*CNT_WIDTH +: CNT_WIDTH]); end
        tick();
        checks += 3;
        if (bus.reach_limit[3] !== 1'b0) begin errors++; $display("FAIL lower_reach_once: got %b expected 0", bus.reach_limit[3]); end
        if (bus.count_flat[3*CNT_WIDTH +: CNT_WIDTH] !== '0) begin errors++; $display("FAIL lower_no_wrap: got %0d expected 0", bus.count_flat[3*CNT_WIDTH +: CNT_WIDTH]); end
        if (bus.busy[3] !== 1'b0) begin errors++; $display("FAIL lower_busy: got %b expected 0", bus.busy[3]); end
    endtask

    task automatic test_independence();
        set_limit(0, 30); set_limit(1, 7); set_limit(2, 12); set_limit(3, 9);
        bus.start = 4'b1111; tick(); bus.start[0] = 1'b0;
        repeat (15) begin
            tick();
            checks += 3;
            if (bus.count_flat !== exp_count()) begin errors++; $display("FAIL indep_count: got %h expected %h", bus.count_flat, exp_count()); end
            if (bus.reach_limit !== exp_reach()) begin errors++; $display("FAIL indep_reach: got %b expected %b", bus.reach_limit, exp_reach()); end
            if (bus.busy !== exp_busy()) begin errors++; $display("FAIL indep_busy: got %b expected %b", bus.busy, exp_busy()); end
        end
        checks++;
        if (bus.busy[0] !== 1'b1) begin errors++; $display("FAIL indep_ch0_running: got %b expected 1", bus.busy[0]); end
        bus.mode[0] = 1'b0;
        tick();
        checks += 3;
        if (bus.count_flat[CNT_WIDTH-1:0] !== '0) begin errors++; $display("FAIL modesw_count: got %0d expected 0", bus.count_flat[CNT_WIDTH-1:0]); end
        if (bus.busy[0] !== 1'b0) begin errors++; $display("FAIL modesw_busy: got %b expected 0", bus.busy[0]); end
        if (bus.reach_limit[0] !== 1'b0) begin errors++; $display("FAIL modesw_reach: got %b expected 0", bus.reach_limit[0]); end
        repeat (20) begin
            tick();
            checks += 3;
            if (bus.count_flat !== exp_count()) begin errors++; $display("FAIL modesw_others_count: got %h expected %h", bus.count_flat, exp_count()); end
            if (bus.reach_limit !== exp_reach()) begin errors++; $display("FAIL modesw_others_reach: got %b expected %b", bus.reach_limit, exp_reach()); end
            if (bus.busy !== exp_busy()) begin errors++; $display("FAIL modesw_others_busy: got %b expected %b", bus.busy, exp_busy()); end
        end
        bus.mode[0] = 1'b1; bus.start = '0;
        repeat (SYNC_STAGES + 2) tick();
    endtask

    task automatic test_random();
        int ch;
        for (int t = 0; t < 600; t++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(99) < 15) bus.start[c] = ~bus.start[c];
                if ($urandom_range(99) < 10) bus.stop[c] = ~bus.stop[c];
                bus.clear[c] = ($urandom_range(99) < 3);
            end
            if ($urandom_range(99) < 2) begin
                ch = int'($urandom_range(NUM_CH - 1));
                bus.mode[ch] = ~bus.mode[ch];
            end
            bus.limit_wr   = ($urandom_range(99) < 6);
            bus.limit_ch   = CH_W'($urandom_range(NUM_CH - 1));
            bus.limit_data = CNT_WIDTH'($urandom_range(15));
            tick();
            checks += 3;
            if (bus.count_flat !== exp_count()) begin errors++; $display("FAIL random_count t=%0d: got %h expected %h", t, bus.count_flat, exp_count()); end
            if (bus.reach_limit !== exp_reach()) begin errors++; $display("FAIL random_reach t=%0d: got %b expected %b", t, bus.reach_limit, exp_reach()); end
            if (bus.busy !== exp_busy()) begin errors++; $display("FAIL random_busy t=%0d: got %b expected %b", t, bus.busy, exp_busy()); end
        end
        bus.start = '0; bus.stop = '0; bus.clear = '0; bus.limit_wr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mode0_periodic();
        test_pause_resume();
        test_clear_priority();
        test_limit_lower();
        test_independence();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
